// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: shares BRAM port B between a video fetch client and an
// aux read/write client. Video has priority, but aux is forced ahead once it
// has waited STARVE_LIMIT consecutive cycles. Read data returns one cycle
// after the grant and is steered to the client that issued the read.
module bram_portb_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_b
);

  // Counter must be able to hold the value STARVE_LIMIT itself.
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]  starve_cnt_r;
  logic              starved_s;
  logic              vid_gnt_s;
  logic              aux_gnt_s;
  logic [ADDR_W-1:0] addr_b_s;
  logic [DATA_W-1:0] data_b_s;
  logic              we_b_s;
  logic              vid_tag_r;
  logic              aux_tag_r;
  logic [DATA_W-1:0] vid_hold_r;
  logic [DATA_W-1:0] aux_hold_r;

  // Pick this cycle's owner; nothing is granted while reset is held low.
  always_comb begin
    starved_s = 1'b0;
    vid_gnt_s = 1'b0;
    aux_gnt_s = 1'b0;
    if (reset == 1'b0) begin
      starved_s = 1'b0;
    end else begin
      starved_s = aux_req && (starve_cnt_r == LIMIT_C);
      if (vid_req && !starved_s) begin
        vid_gnt_s = 1'b1;
      end else if (aux_req) begin
        aux_gnt_s = 1'b1;
      end else begin
        vid_gnt_s = 1'b0;
        aux_gnt_s = 1'b0;
      end
    end
  end

  // Steer the granted client's request onto port B; idle port drives zeros.
  always_comb begin
    addr_b_s = {ADDR_W{1'b0}};
    data_b_s = {DATA_W{1'b0}};
    we_b_s   = 1'b0;
    case ({vid_gnt_s, aux_gnt_s})
      2'b10: begin
        addr_b_s = vid_addr;
      end
      2'b01: begin
        addr_b_s = aux_addr;
        data_b_s = aux_wdata;
        we_b_s   = aux_we;
      end
      default: begin
        addr_b_s = {ADDR_W{1'b0}};
        data_b_s = {DATA_W{1'b0}};
        we_b_s   = 1'b0;
      end
    endcase
  end

  // Count consecutive cycles aux has been kept waiting, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (aux_req && !aux_gnt_s) begin
      if (starve_cnt_r != LIMIT_C) begin
        starve_cnt_r <= starve_cnt_r + ONE_C;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Remember who issued a read so the returning word goes to the right client.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_tag_r <= 1'b0;
      aux_tag_r <= 1'b0;
    end else begin
      vid_tag_r <= vid_gnt_s;
      aux_tag_r <= aux_gnt_s && !aux_we;
    end
  end

  // Capture each delivered word so rdata holds it after rvalid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_hold_r <= {DATA_W{1'b0}};
      aux_hold_r <= {DATA_W{1'b0}};
    end else begin
      if (vid_tag_r) begin
        vid_hold_r <= q_b;
      end else begin
        vid_hold_r <= vid_hold_r;
      end
      if (aux_tag_r) begin
        aux_hold_r <= q_b;
      end else begin
        aux_hold_r <= aux_hold_r;
      end
    end
  end

  assign vid_gnt    = vid_gnt_s;
  assign aux_gnt    = aux_gnt_s;
  assign addr_b     = addr_b_s;
  assign data_b     = data_b_s;
  assign we_b       = we_b_s;
  assign vid_rvalid = vid_tag_r;
  assign aux_rvalid = aux_tag_r;
  assign vid_rdata  = vid_tag_r ? q_b : vid_hold_r;
  assign aux_rdata  = aux_tag_r ? q_b : aux_hold_r;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: a behavioural BRAM on port B, a reference
// model of the arbitration rules and read returns, directed scenarios and a
// randomized phase with occasional mid-operation resets.
module tb_bram_portb_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [15:0] vid_rdata;
  logic        aux_req;
  logic        aux_we;
  logic [15:0] aux_addr;
  logic [15:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [15:0] aux_rdata;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic [15:0] q_b = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  bram_portb_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  // Power-up contents of the memory; 0x40 holds the known video word.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Behavioural BRAM port B: synchronous write, one-cycle read latency.
  logic [15:0] bram [0:65535];
  bit          written [0:65535];
  always @(posedge clk) begin
    if (we_b) begin
      bram[addr_b]    <= data_b;
      written[addr_b] <= 1'b1;
    end
    q_b <= written[addr_b] ? bram[addr_b] : init_val(addr_b);
  end

  // Reference model state
  logic [15:0] shadow [int];
  int          waits = 0;
  bit          pend_v = 0, pend_a = 0;
  logic [15:0] pend_vd = 16'h0, pend_ad = 16'h0, last_v = 16'h0, last_a = 16'h0;
  bit          last_gv = 0, last_ga = 0;

  function automatic logic [15:0] shadow_rd(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven after a negedge; check, advance model.
  task automatic step();
    bit          eg_v, eg_a, ew;
    logic [15:0] ea, ed;
    #1;
    if (!reset) begin
      pend_v = 0; pend_a = 0; last_v = 16'h0; last_a = 16'h0; waits = 0;
      eg_v = 0; eg_a = 0;
    end else begin
      eg_v = vid_req && !(aux_req && waits >= LIMIT);
      eg_a = aux_req && !eg_v;
    end
    ea = eg_v ? vid_addr : (eg_a ? aux_addr : 16'h0000);
    ed = eg_a ? aux_wdata : 16'h0000;
    ew = eg_a && aux_we;
    check("vid_gnt",    32'(vid_gnt),    32'(eg_v));
    check("aux_gnt",    32'(aux_gnt),    32'(eg_a));
    check("addr_b",     32'(addr_b),     32'(ea));
    check("data_b",     32'(data_b),     32'(ed));
    check("we_b",       32'(we_b),       32'(ew));
    check("vid_rvalid", 32'(vid_rvalid), 32'(pend_v));
    check("aux_rvalid", 32'(aux_rvalid), 32'(pend_a));
    check("vid_rdata",  32'(vid_rdata),  32'(pend_v ? pend_vd : last_v));
    check("aux_rdata",  32'(aux_rdata),  32'(pend_a ? pend_ad : last_a));
    last_gv = eg_v;
    last_ga = eg_a;
    @(posedge clk);
    if (reset) begin
      if (pend_v) last_v = pend_vd;
      if (pend_a) last_a = pend_ad;
      pend_v  = eg_v;
      pend_vd = shadow_rd(vid_addr);
      pend_a  = eg_a && !aux_we;
      pend_ad = shadow_rd(aux_addr);
      if (eg_a && aux_we) shadow[int'(aux_addr)] = aux_wdata;
      if (aux_req && !eg_a) waits = (waits + 1 > LIMIT) ? LIMIT : waits + 1;
      else waits = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; vid_req = 1'b0; vid_addr = 16'h0; aux_req = 1'b0;
    aux_we = 1'b0; aux_addr = 16'h0; aux_wdata = 16'h0;
    @(negedge clk);
    // Reset state, with requests active to prove they are masked
    vid_req = 1'b1; aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0011; aux_wdata = 16'hAAAA;
    step();
    vid_req = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    step();
    reset = 1'b1;

    // Single video read of 0x40, data one cycle later
    vid_req = 1'b1; vid_addr = 16'h0040;
    #1 check("vid_gnt_first_edge", 32'(vid_gnt), 32'd1);
    step();
    vid_req = 1'b0;
    #1 check("vid_beef", 32'(vid_rdata), 32'h0000BEEF);
    step();

    // Aux write then read-back
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0100; aux_wdata = 16'h1234;
    #1 check("aux_we_b", 32'({we_b, addr_b, data_b}), 32'({1'b1, 16'h0100, 16'h1234}));
    step();
    aux_we = 1'b0; aux_wdata = 16'h0000;
    #1 check("aux_wr_no_rvalid", 32'(aux_rvalid), 32'd0);
    step();
    aux_req = 1'b0;
    #1 check("aux_rd_1234", 32'(aux_rdata), 32'h00001234);
    step();

    // Both held: 8 video grants then one forced aux grant, repeating
    vid_req = 1'b1; vid_addr = 16'h0022; aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0033;
    for (int i = 0; i < 27; i++) begin
      #1 check("starve_pattern", 32'(aux_gnt), 32'(i % 9 == 8));
      step();
    end
    vid_req = 1'b0; aux_req = 1'b0;
    step();

    // Alternating video/aux reads every cycle
    for (int i = 0; i < 12; i++) begin
      vid_req  = (i % 2 == 0);
      aux_req  = (i % 2 == 1);
      vid_addr = 16'(16'h0040 + i);
      aux_addr = 16'(16'h0100 + i);
      step();
    end
    vid_req = 1'b0; aux_req = 1'b0;
    step();

    // Aux drops after 5 waits, re-raised: 8 fresh waits before forced grant
    vid_req = 1'b1; vid_addr = 16'h0050; aux_req = 1'b1; aux_addr = 16'h0060;
    for (int i = 0; i < 5; i++) step();
    aux_req = 1'b0;
    step();
    aux_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1 check("restart_wait", 32'(aux_gnt), 32'(i == 8));
      step();
    end
    vid_req = 1'b0; aux_req = 1'b0;
    step();

    // Reset the cycle after an aux read grant: read is discarded
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0100;
    step();
    aux_req = 1'b0; reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1 check("no_rvalid_after_reset", 32'(aux_rvalid), 32'd0);
    step();

    // Randomized traffic with occasional reset pulses
    vid_req = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!vid_req || last_gv) begin
        vid_req  = ($urandom_range(0, 99) < 55);
        vid_addr = 16'($urandom_range(0, 127));
      end
      if (!aux_req || last_ga) begin
        aux_req   = ($urandom_range(0, 99) < 50);
        aux_we    = ($urandom_range(0, 1) == 1);
        aux_addr  = 16'($urandom_range(0, 127));
        aux_wdata = 16'($urandom);
      end
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1;
    vid_req = 1'b0; aux_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_portb_arbiter.md
BRAM_PORTB_ARBITER -- requirements
Module: bram_portb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, BRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, BRAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, number of consecutive aux wait cycles before aux is forced ahead of video.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vid_req, input, 1, video fetch request; held high with vid_addr stable until granted.
REQ-007 SHALL have port vid_addr, input, ADDR_W, video read address.
REQ-008 SHALL have port vid_gnt, output, 1, video access issued this cycle.
REQ-009 SHALL have port vid_rvalid, output, 1, video read data valid.
REQ-010 SHALL have port vid_rdata, output, DATA_W, video read data.
REQ-011 SHALL have port aux_req, input, 1, aux request; held high with aux_we, aux_addr and aux_wdata stable until granted.
REQ-012 SHALL have port aux_we, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port aux_addr, input, ADDR_W, aux address.
REQ-014 SHALL have port aux_wdata, input, DATA_W, aux write data.
REQ-015 SHALL have port aux_gnt, output, 1, aux access issued this cycle.
REQ-016 SHALL have port aux_rvalid, output, 1, aux read data valid.
REQ-017 SHALL have port aux_rdata, output, DATA_W, aux read data.
REQ-018 SHALL have port addr_b, output, ADDR_W, BRAM port-B address.
REQ-019 SHALL have port data_b, output, DATA_W, BRAM port-B write data.
REQ-020 SHALL have port we_b, output, 1, BRAM port-B write enable.
REQ-021 SHALL have port q_b, input, DATA_W, BRAM port-B read data, valid the cycle after address issue.

Function
REQ-022 SHALL arbitrate combinationally each cycle and issue at most one access per cycle; vid_gnt and aux_gnt are never both high.
REQ-023 SHALL grant video when vid_req=1, unless aux_req=1 and starve_cnt==STARVE_LIMIT, in which case aux is granted.
REQ-024 SHALL grant aux when aux_req=1 and either vid_req=0 or the starvation condition of REQ-023 holds.
REQ-025 SHALL drive addr_b, data_b and we_b from the granted requester (we_b=aux_we on an aux grant, 0 on a video grant), and 0/0/0 when there is no grant.
REQ-026 SHALL keep starve_cnt: increment on each cycle with aux_req=1 and aux_gnt=0, saturate at STARVE_LIMIT, clear on an aux grant or when aux_req=0.
REQ-027 SHALL register a read-owner tag at each read grant and pulse the matching rvalid for exactly one cycle, the cycle after the grant (latency 1).
REQ-028 SHALL drive rdata of the tagged owner as q_b while its rvalid=1, and hold the last captured value otherwise.
REQ-029 SHALL never assert aux_rvalid for an aux write.
REQ-030 SHALL sustain back-to-back grants with one access per cycle and overlapping rvalid pipelining.
REQ-031 SHALL leave a requester's rvalid unaffected when it deasserts req after its grant.

Reset
REQ-032 SHALL, while reset=0, force both grants, both rvalids, we_b, addr_b and data_b to 0.
REQ-033 SHALL clear vid_rdata, aux_rdata, starve_cnt and the read-owner tag to 0 on reset.
REQ-034 SHALL discard an in-flight read when reset asserts mid-operation: no rvalid after reset release.
REQ-035 SHALL allow grants on the first clock edge after reset release.

Verification
REQ-036 SHALL pass: vid_req only, vid_addr=0x0040, BRAM[0x40]=0xBEEF -> vid_gnt in cycle N, vid_rvalid=1 and vid_rdata=0xBEEF in N+1.
REQ-037 SHALL pass: aux write aux_addr=0x0100, aux_wdata=0x1234, no vid_req -> we_b=1, addr_b=0x0100, data_b=0x1234 for one cycle, no aux_rvalid; then aux read 0x0100 -> aux_rdata=0x1234.
REQ-038 SHALL pass: vid_req and aux_req held continuously -> video granted 8 cycles, aux granted on cycle 9, then video again; pattern repeats.
REQ-039 SHALL pass: alternating vid/aux reads every cycle -> each rvalid returns the correct owner's data with no cross-delivery.
REQ-040 SHALL pass: reset=0 asserted the cycle after an aux read grant -> aux_rvalid stays 0; all outputs 0 during reset.
REQ-041 SHALL pass: aux_req drops after 5 wait cycles and is re-raised -> starve_cnt restarts at 0, and aux is forced only after 8 further wait cycles.
